buffer_ring_ctrl: RTL and testbench

Parametrised N-slot frame-buffer ring controller between the sample writer (producer) and the wave display (consumer). It tracks which slot the producer fills, which slot the display reads, and how many completed slots are queued. It advances the display to the next completed slot only at a display-idle boundary, so a frame is never shown while it is being written. With NUM_BUFS=2 it acts as a ping-pong double-buffer swap. Larger rings allow the producer to run ahead of the display by up to NUM_BUFS-1 frames.

---
 rtl/buffer_ring_ctrl_if.sv | 37 +++
 rtl/buffer_ring_ctrl.sv | 125 ++++++++++++
 tb/tb_buffer_ring_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_ring_ctrl_if.sv
// rtl/buffer_ring_ctrl_if.sv - producer/display handshake and ring status bundle for buffer_ring_ctrl
interface buffer_ring_ctrl_if #(
    parameter int IDX_W = 2
);
    logic             producer_active;
    logic             display_idle;
    logic [IDX_W-1:0] read_index;
    logic [IDX_W-1:0] write_index;
    logic [IDX_W-1:0] pending;
    logic             flip;
    logic             write_stall;
    logic             overrun;

    // producer/display side: drives activity levels, observes ring state
    modport master (
        output producer_active,
        output display_idle,
        input  read_index,
        input  write_index,
        input  pending,
        input  flip,
        input  write_stall,
        input  overrun
    );

    // ring controller side
    modport slave (
        input  producer_active,
        input  display_idle,
        output read_index,
        output write_index,
        output pending,
        output flip,
        output write_stall,
        output overrun
    );
endinterface

// File: rtl/buffer_ring_ctrl.sv
// rtl/buffer_ring_ctrl.sv - N-slot frame-buffer ring controller; optional feature macro RING_OVERWRITE_EN
module buffer_ring_ctrl #(
    parameter int NUM_BUFS = 4,
    parameter int IDX_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    buffer_ring_ctrl_if.slave ring
);
    localparam logic [IDX_W-1:0] LP_LAST    = IDX_W'(NUM_BUFS - 1);
    localparam logic [IDX_W-1:0] LP_RECLAIM = IDX_W'(NUM_BUFS - 2);
    localparam logic [IDX_W-1:0] LP_ONE     = IDX_W'(1);

    // Slot increment wraps at NUM_BUFS, not at the index width
    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] idx);
        return (idx == LP_LAST) ? '0 : idx + LP_ONE;
    endfunction

    logic             r_prod_d;
    logic             r_idle_d;
    logic [IDX_W-1:0] r_rd;
    logic [IDX_W-1:0] r_wr;
    logic [IDX_W-1:0] r_pend;
    logic             r_flip;
    logic             r_overrun;
    logic             r_stall;
    logic             r_stalled;

    logic             w_start;
    logic             w_done;
    logic             w_idle_edge;
    logic [IDX_W-1:0] w_rd_nxt;
    logic [IDX_W-1:0] w_wr_nxt;
    logic [IDX_W-1:0] w_pend_nxt;
    logic             w_flip_nxt;
    logic             w_ovr_nxt;
    logic             w_stall_nxt;
    logic             w_stalled_nxt;

    assign w_start     = ring.producer_active & ~r_prod_d;
    assign w_done      = ~ring.producer_active & r_prod_d;
    assign w_idle_edge = ring.display_idle & ~r_idle_d;

    // Flip, then start, then done, each seeing the result of the previous step
    always_comb begin
        w_rd_nxt      = r_rd;
        w_wr_nxt      = r_wr;
        w_pend_nxt    = r_pend;
        w_flip_nxt    = 1'b0;
        w_ovr_nxt     = 1'b0;
        w_stalled_nxt = r_stalled;

        // Display boundary: advance to the oldest completed slot, if any
        if (w_idle_edge && (r_pend != '0)) begin
            w_rd_nxt   = f_inc(r_rd);
            w_pend_nxt = r_pend - LP_ONE;
            w_flip_nxt = 1'b1;
            // A full ring had no free slot; the one just released becomes the write slot
            if (r_pend == LP_LAST) begin
                w_wr_nxt = r_rd;
            end
        end

        if (w_start && (w_pend_nxt == LP_LAST)) begin
            w_ovr_nxt = 1'b1;
`ifdef RING_OVERWRITE_EN
            // Drop the newest queued frame; write_index already names that slot
            w_pend_nxt = LP_RECLAIM;
`else
            // Reject the frame; its done edge must not count as a completed slot
            w_stalled_nxt = 1'b1;
`endif
        end

        if (w_done) begin
            if (r_stalled) begin
                w_stalled_nxt = 1'b0;
            end else if (w_pend_nxt != LP_LAST) begin
                w_pend_nxt = w_pend_nxt + LP_ONE;
                // Once full, write_index stays on the newest completed slot
                if (w_pend_nxt != LP_LAST) begin
                    w_wr_nxt = f_inc(w_wr_nxt);
                end
            end
        end

`ifdef RING_OVERWRITE_EN
        w_stall_nxt = 1'b0;
`else
        w_stall_nxt = (w_pend_nxt == LP_LAST);
`endif
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod_d  <= 1'b0;
            r_idle_d  <= 1'b0;
            r_rd      <= '0;
            r_wr      <= LP_ONE;
            r_pend    <= '0;
            r_flip    <= 1'b0;
            r_overrun <= 1'b0;
            r_stall   <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_prod_d  <= ring.producer_active;
            r_idle_d  <= ring.display_idle;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_pend    <= w_pend_nxt;
            r_flip    <= w_flip_nxt;
            r_overrun <= w_ovr_nxt;
            r_stall   <= w_stall_nxt;
            r_stalled <= w_stalled_nxt;
        end
    end

    assign ring.read_index  = r_rd;
    assign ring.write_index = r_wr;
    assign ring.pending     = r_pend;
    assign ring.flip        = r_flip;
    assign ring.write_stall = r_stall;
    assign ring.overrun     = r_overrun;
endmodule

// File: tb/tb_buffer_ring_ctrl.sv
// tb/tb_buffer_ring_ctrl.sv - directed self-checking bench for buffer_ring_ctrl (rings of 2, 3 and 4 slots)
module tb_buffer_ring_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] pa;
    logic [2:0] di;
    logic [1:0] rd [3];
    logic [1:0] wr [3];
    logic [1:0] pd [3];
    logic       fl [3];
    logic       ws [3];
    logic       ov [3];
    int         fl_cnt [3];
    int         ov_cnt [3];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    buffer_ring_ctrl_if #(.IDX_W(2)) if2 ();
    buffer_ring_ctrl_if #(.IDX_W(2)) if3 ();
    buffer_ring_ctrl_if #(.IDX_W(2)) if4 ();

    assign if2.producer_active = pa[0];
    assign if2.display_idle    = di[0];
    assign if3.producer_active = pa[1];
    assign if3.display_idle    = di[1];
    assign if4.producer_active = pa[2];
    assign if4.display_idle    = di[2];

    assign rd[0] = if2.read_index;  assign wr[0] = if2.write_index;  assign pd[0] = if2.pending;
    assign fl[0] = if2.flip;        assign ws[0] = if2.write_stall;  assign ov[0] = if2.overrun;
    assign rd[1] = if3.read_index;  assign wr[1] = if3.write_index;  assign pd[1] = if3.pending;
    assign fl[1] = if3.flip;        assign ws[1] = if3.write_stall;  assign ov[1] = if3.overrun;
    assign rd[2] = if4.read_index;  assign wr[2] = if4.write_index;  assign pd[2] = if4.pending;
    assign fl[2] = if4.flip;        assign ws[2] = if4.write_stall;  assign ov[2] = if4.overrun;

    buffer_ring_ctrl #(.NUM_BUFS(2), .IDX_W(2)) u_dut2 (.clk(clk), .reset(reset), .ring(if2));
    buffer_ring_ctrl #(.NUM_BUFS(3), .IDX_W(2)) u_dut3 (.clk(clk), .reset(reset), .ring(if3));
    buffer_ring_ctrl #(.NUM_BUFS(4), .IDX_W(2)) u_dut4 (.clk(clk), .reset(reset), .ring(if4));

    // Pulse counters sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (fl[k] === 1'b1) fl_cnt[k] <= fl_cnt[k] + 1;
            if (ov[k] === 1'b1) ov_cnt[k] <= ov_cnt[k] + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int k);
        pa[k] = 1'b1;
        cyc(3);
        pa[k] = 1'b0;
        cyc(2);
    endtask

    task automatic idle_rise(input int k);
        di[k] = 1'b1;
        cyc(2);
        di[k] = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset;
        int f0;
        reset = 1'b0;
        pa    = '0;
        di    = '0;
        for (int k = 0; k < 3; k++) begin
            fl_cnt[k] = 0;
            ov_cnt[k] = 0;
        end
        cyc(2);
        n_checks++;
        if ({rd[0], wr[0], pd[0], fl[0], ws[0], ov[0]} !== {2'd0, 2'd1, 2'd0, 3'b000}) begin
            $display("FAIL reset_values: rd=%0d wr=%0d pend=%0d flip=%0b stall=%0b ovr=%0b, required 0 1 0 0 0 0",
                     rd[0], wr[0], pd[0], fl[0], ws[0], ov[0]);
            n_errors++;
        end
        reset = 1'b1;
        cyc(2);
        f0 = fl_cnt[0];
        idle_rise(0);
        n_checks++;
        if ({rd[0], wr[0], pd[0]} !== {2'd0, 2'd1, 2'd0} || fl_cnt[0] != f0) begin
            $display("FAIL empty_idle: rd=%0d wr=%0d pend=%0d flips=%0d, required 0 1 0 0",
                     rd[0], wr[0], pd[0], fl_cnt[0] - f0);
            n_errors++;
        end
    endtask

    task automatic test_ping_pong;
        int f0;
        frame(0);
        n_checks++;
        if ({rd[0], wr[0], pd[0], ws[0]} !== {2'd0, 2'd1, 2'd1, 1'b1} &&
            {rd[0], wr[0], pd[0]} !== {2'd0, 2'd1, 2'd1}) begin
            $display("FAIL pp_after_frame: rd=%0d wr=%0d pend=%0d, required 0 1 1", rd[0], wr[0], pd[0]);
            n_errors++;
        end
        f0 = fl_cnt[0];
        idle_rise(0);
        n_checks++;
        if ({rd[0], wr[0], pd[0]} !== {2'd1, 2'd0, 2'd0}) begin
            $display("FAIL pp_after_flip: rd=%0d wr=%0d pend=%0d, required 1 0 0", rd[0], wr[0], pd[0]);
            n_errors++;
        end
        n_checks++;
        if (fl_cnt[0] - f0 != 1) begin
            $display("FAIL pp_flip_pulse: flip cycles=%0d, required 1", fl_cnt[0] - f0);
            n_errors++;
        end
    endtask

    task automatic test_fill_stall;
        int o0;
        frame(2);
        frame(2);
        frame(2);
        n_checks++;
        if ({rd[2], wr[2], pd[2]} !== {2'd0, 2'd3, 2'd3}) begin
            $display("FAIL fill_state: rd=%0d wr=%0d pend=%0d, required 0 3 3", rd[2], wr[2], pd[2]);
            n_errors++;
        end
        n_checks++;
`ifdef RING_OVERWRITE_EN
        if (ws[2] !== 1'b0) begin
            $display("FAIL fill_stall: stall=%0b, required 0", ws[2]);
            n_errors++;
        end
`else
        if (ws[2] !== 1'b1) begin
            $display("FAIL fill_stall: stall=%0b, required 1", ws[2]);
            n_errors++;
        end
`endif
        o0 = ov_cnt[2];
        pa[2] = 1'b1;
        cyc(3);
        n_checks++;
        if (ov_cnt[2] - o0 != 1) begin
            $display("FAIL full_start_overrun: overrun cycles=%0d, required 1", ov_cnt[2] - o0);
            n_errors++;
        end
        n_checks++;
`ifdef RING_OVERWRITE_EN
        if ({rd[2], wr[2], pd[2]} !== {2'd0, 2'd3, 2'd2}) begin
            $display("FAIL full_start_state: rd=%0d wr=%0d pend=%0d, required 0 3 2", rd[2], wr[2], pd[2]);
            n_errors++;
        end
`else
        if ({rd[2], wr[2], pd[2]} !== {2'd0, 2'd3, 2'd3}) begin
            $display("FAIL full_start_state: rd=%0d wr=%0d pend=%0d, required 0 3 3", rd[2], wr[2], pd[2]);
            n_errors++;
        end
`endif
        idle_rise(2);
        n_checks++;
`ifdef RING_OVERWRITE_EN
        if ({rd[2], wr[2], pd[2], ws[2]} !== {2'd1, 2'd3, 2'd1, 1'b0}) begin
            $display("FAIL full_flip: rd=%0d wr=%0d pend=%0d stall=%0b, required 1 3 1 0", rd[2], wr[2], pd[2], ws[2]);
            n_errors++;
        end
`else
        if ({rd[2], wr[2], pd[2], ws[2]} !== {2'd1, 2'd0, 2'd2, 1'b0}) begin
            $display("FAIL full_flip: rd=%0d wr=%0d pend=%0d stall=%0b, required 1 0 2 0", rd[2], wr[2], pd[2], ws[2]);
            n_errors++;
        end
`endif
        pa[2] = 1'b0;
        cyc(2);
        n_checks++;
        if ({rd[2], wr[2], pd[2]} !== {2'd1, 2'd0, 2'd2}) begin
            $display("FAIL after_full_done: rd=%0d wr=%0d pend=%0d, required 1 0 2", rd[2], wr[2], pd[2]);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back;
        int f0;
        idle_rise(2);
        n_checks++;
        if ({rd[2], wr[2], pd[2]} !== {2'd2, 2'd0, 2'd1}) begin
            $display("FAIL b2b_setup: rd=%0d wr=%0d pend=%0d, required 2 0 1", rd[2], wr[2], pd[2]);
            n_errors++;
        end
        pa[2] = 1'b1;
        cyc(3);
        f0 = fl_cnt[2];
        pa[2] = 1'b0;
        di[2] = 1'b1;
        cyc(2);
        di[2] = 1'b0;
        cyc(1);
        n_checks++;
        if ({rd[2], wr[2], pd[2]} !== {2'd3, 2'd1, 2'd1} || fl_cnt[2] - f0 != 1) begin
            $display("FAIL flip_with_done: rd=%0d wr=%0d pend=%0d flips=%0d, required 3 1 1 1",
                     rd[2], wr[2], pd[2], fl_cnt[2] - f0);
            n_errors++;
        end
    endtask

    task automatic test_ring3;
        int o0;
        frame(1);
        frame(1);
        n_checks++;
        if ({rd[1], wr[1], pd[1]} !== {2'd0, 2'd2, 2'd2}) begin
            $display("FAIL r3_fill: rd=%0d wr=%0d pend=%0d, required 0 2 2", rd[1], wr[1], pd[1]);
            n_errors++;
        end
        o0 = ov_cnt[1];
        pa[1] = 1'b1;
        cyc(3);
        n_checks++;
`ifdef RING_OVERWRITE_EN
        if ({wr[1], pd[1], ws[1]} !== {2'd2, 2'd1, 1'b0} || ov_cnt[1] - o0 != 1) begin
            $display("FAIL r3_reclaim: wr=%0d pend=%0d stall=%0b overruns=%0d, required 2 1 0 1",
                     wr[1], pd[1], ws[1], ov_cnt[1] - o0);
            n_errors++;
        end
`else
        if ({wr[1], pd[1], ws[1]} !== {2'd2, 2'd2, 1'b1} || ov_cnt[1] - o0 != 1) begin
            $display("FAIL r3_reject: wr=%0d pend=%0d stall=%0b overruns=%0d, required 2 2 1 1",
                     wr[1], pd[1], ws[1], ov_cnt[1] - o0);
            n_errors++;
        end
`endif
        idle_rise(1);
        n_checks++;
        if (rd[1] !== 2'd1 || rd[1] === wr[1]) begin
            $display("FAIL r3_display_slot: rd=%0d wr=%0d, required rd 1 and rd != wr", rd[1], wr[1]);
            n_errors++;
        end
        pa[1] = 1'b0;
        cyc(2);
        n_checks++;
        if ({rd[1], wr[1], pd[1]} !== {2'd1, 2'd0, 2'd1}) begin
            $display("FAIL r3_after_done: rd=%0d wr=%0d pend=%0d, required 1 0 1", rd[1], wr[1], pd[1]);
            n_errors++;
        end
        frame(1);
        idle_rise(1);
        idle_rise(1);
        n_checks++;
        if ({rd[1], wr[1], pd[1]} !== {2'd0, 2'd1, 2'd0}) begin
            $display("FAIL r3_wrap: rd=%0d wr=%0d pend=%0d, required 0 1 0", rd[1], wr[1], pd[1]);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid;
        int f0;
        frame(2);
        n_checks++;
        if ({rd[2], wr[2], pd[2]} !== {2'd3, 2'd2, 2'd2}) begin
            $display("FAIL mid_setup: rd=%0d wr=%0d pend=%0d, required 3 2 2", rd[2], wr[2], pd[2]);
            n_errors++;
        end
        pa[2] = 1'b1;
        cyc(2);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rd[2], wr[2], pd[2], fl[2], ws[2], ov[2]} !== {2'd0, 2'd1, 2'd0, 3'b000}) begin
            $display("FAIL async_reset: rd=%0d wr=%0d pend=%0d flip=%0b stall=%0b ovr=%0b, required 0 1 0 0 0 0",
                     rd[2], wr[2], pd[2], fl[2], ws[2], ov[2]);
            n_errors++;
        end
        pa[2] = 1'b0;
        di[2] = 1'b1;
        cyc(1);
        reset = 1'b1;
        f0 = fl_cnt[2];
        cyc(3);
        n_checks++;
        if ({rd[2], wr[2], pd[2]} !== {2'd0, 2'd1, 2'd0} || fl_cnt[2] != f0) begin
            $display("FAIL post_reset_idle: rd=%0d wr=%0d pend=%0d flips=%0d, required 0 1 0 0",
                     rd[2], wr[2], pd[2], fl_cnt[2] - f0);
            n_errors++;
        end
        di[2] = 1'b0;
        cyc(1);
    endtask

    initial begin
        test_reset;
        test_ping_pong;
        test_fill_stall;
        test_back_to_back;
        test_ring3;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
